// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared types for the CU read-command path: command struct, command kinds and CU ID helpers.
package cu_read_command_arbiter_pkg;

  localparam int CU_ID_W = 8;

  typedef logic [CU_ID_W-1:0] cu_id_t;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_READ,
    CMD_WRITE,
    CMD_PREFETCH
  } cmd_type_t;

  typedef struct packed {
    logic [0:63] address;
    logic [0:11] size;
    cmd_type_t   cmd_type;
    cu_id_t      cu_id;
  } cu_cmd_t;

  // CU IDs wrap modulo 256, so base + index is deliberately truncated.
  function automatic cu_id_t stamp_cu_id(input cu_id_t base, input cu_id_t idx);
    return cu_id_t'(base + idx);
  endfunction

endpackage

// File: rtl/cu_read_command_arbiter_if.sv
// Request, output and response handshake bundle between the read CUs, the arbiter and the AFU command buffer.
interface cu_read_command_arbiter_if #(
  parameter int NUM_REQ = 8
);
  import cu_read_command_arbiter_pkg::*;

  logic    [NUM_REQ-1:0] req_valid;
  cu_cmd_t [NUM_REQ-1:0] req_cmd;
  logic    [NUM_REQ-1:0] req_ready;
  logic                  out_valid;
  cu_cmd_t               out_cmd;
  logic                  out_ready;
  logic                  rsp_valid;
  cu_id_t                rsp_cu_id;

  // master: the arbiter itself
  modport master (
    input  req_valid, req_cmd, out_ready, rsp_valid, rsp_cu_id,
    output req_ready, out_valid, out_cmd
  );

  // slave: the CUs, downstream buffer and response path around the arbiter
  modport slave (
    output req_valid, req_cmd, out_ready, rsp_valid, rsp_cu_id,
    input  req_ready, out_valid, out_cmd
  );

endinterface

// File: rtl/cu_read_command_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module round_robin_arbiter_N_input #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant
);

  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      idx = sum[PW-1:0];
      if (enable && !found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Round-robin arbiter sharing the AFU read-command channel among NUM_REQ CUs,
// with a one-entry output slot and per-CU outstanding-command credit counters.
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int     NUM_REQ         = 8,
  parameter int     MAX_OUTSTANDING = 16,
  parameter cu_id_t CU_ID_BASE      = 8'h01,
  parameter int     CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enabled_in,
  cu_read_command_arbiter_if.master    bus,
  output logic [NUM_REQ-1:0][CW-1:0]   outstanding_out
);

  localparam int            PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      ptr_next;
  logic               out_valid_reg;
  cu_cmd_t            out_cmd_reg;
  logic [CW-1:0]      cnt_reg [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  logic               arb_enable;
  logic               any_grant;
  logic [PW-1:0]      win;
  cu_cmd_t            stamped_cmd;
  cu_id_t             rsp_idx;
  logic               rsp_hit;

  // The slot accepts a new command if empty or being drained this cycle; reset masks grants.
  assign slot_free  = !out_valid_reg || bus.out_ready;
  assign arb_enable = rstn && enabled_in && slot_free;

  round_robin_arbiter_N_input #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .request (elig),
    .ptr     (ptr_reg),
    .enable  (arb_enable),
    .grant   (grant)
  );

  assign bus.req_ready = grant;
  assign any_grant     = |grant;

  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win = PW'(k);
      end
    end
  end

  always_comb begin
    stamped_cmd       = bus.req_cmd[win];
    stamped_cmd.cu_id = stamp_cu_id(CU_ID_BASE, cu_id_t'(win));
  end

  assign ptr_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

  always_ff @(posedge clock) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      out_cmd_reg   <= '0;
      ptr_reg       <= '0;
    end else if (any_grant) begin
      out_valid_reg <= 1'b1;
      out_cmd_reg   <= stamped_cmd;
      ptr_reg       <= ptr_next;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_cmd   = out_cmd_reg;

  // Responses carrying IDs outside this arbiter's range are ignored.
  assign rsp_idx = bus.rsp_cu_id - CU_ID_BASE;
  assign rsp_hit = bus.rsp_valid && (rsp_idx < cu_id_t'(NUM_REQ));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_credit
    logic inc;
    logic dec;

    assign inc = grant[gi];
    assign dec = rsp_hit && (rsp_idx == cu_id_t'(gi));

    always_ff @(posedge clock) begin
      if (!rstn) begin
        cnt_reg[gi] <= '0;
      end else if (inc && !dec) begin
        cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
      end else if (dec && !inc && (cnt_reg[gi] != '0)) begin
        cnt_reg[gi] <= cnt_reg[gi] - CW'(1);
      end
    end

    assign elig[gi]            = bus.req_valid[gi] && (cnt_reg[gi] < MAX_CNT);
    assign outstanding_out[gi] = cnt_reg[gi];
  end

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Directed bench for the CU read-command arbiter: reset, fairness, backpressure, credits, enable, mid-stream reset.
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int NUM_REQ = 8;
  localparam int CW      = 5;

  logic clock      = 1'b0;
  logic rstn       = 1'b0;
  logic enabled_in = 1'b0;
  logic [NUM_REQ-1:0][CW-1:0] outstanding_out;

  int checks   = 0;
  int failures = 0;

  cu_read_command_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  cu_read_command_arbiter #(
    .NUM_REQ         (NUM_REQ),
    .MAX_OUTSTANDING (16),
    .CU_ID_BASE      (8'h01)
  ) dut (
    .clock           (clock),
    .rstn            (rstn),
    .enabled_in      (enabled_in),
    .bus             (bus),
    .outstanding_out (outstanding_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic do_reset();
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_cu_id = '0;
    bus.out_ready = 1'b1;
    enabled_in    = 1'b1;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    cu_cmd_t    c;
    logic [7:0] exp_ready;
    int         grants;

    for (int i = 0; i < NUM_REQ; i++) begin
      c          = '0;
      c.address  = 64'hA000 + 64'(i);
      c.size     = 12'd64;
      c.cmd_type = CMD_READ;
      bus.req_cmd[i] = c;
    end
    bus.out_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_cu_id = '0;
    enabled_in    = 1'b1;

    // 1. reset: requests held high must not be granted while rstn is low
    rstn          = 1'b0;
    bus.req_valid = '1;
    @(negedge clock); #1;
    check_eq("rst_ready_forced0", 64'(bus.req_ready), 64'h0);
    @(negedge clock);
    bus.req_valid = '0;
    rstn          = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check_eq("rst_out_cmd_zero", 64'(|bus.out_cmd), 64'h0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check_eq("rst_outstanding", 64'(outstanding_out), 64'h0);

    // 2. fairness: grants 0..7,0 with cu_id 1..8,1
    bus.req_valid = '1;
    #1;
    check_eq("fair_ready_first", 64'(bus.req_ready), 64'h01);
    for (int k = 0; k < 9; k++) begin
      @(negedge clock); #1;
      exp_ready = 8'h01 << ((k + 1) % 8);
      check_eq("fair_out_valid", 64'(bus.out_valid), 64'h1);
      check_eq("fair_cu_id", 64'(bus.out_cmd.cu_id), 64'(8'h01 + 8'(k % 8)));
      check_eq("fair_next_ready", 64'(bus.req_ready), 64'(exp_ready));
    end
    bus.req_valid = '0;
    @(negedge clock); #1;
    check_eq("fair_cnt0", 64'(outstanding_out[0]), 64'd2);
    check_eq("fair_cnt7", 64'(outstanding_out[7]), 64'd1);
    check_eq("fair_drain", 64'(bus.out_valid), 64'h0);

    // 3. backpressure: out_cmd held for 5+ cycles, then 1 per cycle
    do_reset();
    bus.out_ready = 1'b0;
    bus.req_valid = 8'h01;
    #1;
    check_eq("bp_first_ready", 64'(bus.req_ready), 64'h01);
    @(negedge clock);
    bus.req_cmd[0].address = 64'hB000;
    #1;
    check_eq("bp_valid", 64'(bus.out_valid), 64'h1);
    check_eq("bp_ready_blocked", 64'(bus.req_ready), 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      check_eq("bp_hold_valid", 64'(bus.out_valid), 64'h1);
      check_eq("bp_hold_addr", 64'(bus.out_cmd.address), 64'hA000);
      check_eq("bp_hold_ready", 64'(bus.req_ready), 64'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(bus.req_ready), 64'h01);
    @(negedge clock); #1;
    check_eq("bp_new_addr", 64'(bus.out_cmd.address), 64'hB000);
    check_eq("bp_b2b_ready", 64'(bus.req_ready), 64'h01);
    @(negedge clock); #1;
    check_eq("bp_cnt0", 64'(outstanding_out[0]), 64'd3);
    bus.req_valid = '0;
    bus.req_cmd[0].address = 64'hA000;

    // 4. credit limit on CU3
    do_reset();
    bus.req_valid = 8'h08;
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[3]) grants++;
      @(negedge clock);
    end
    #1;
    check_eq("cred_grants", 64'(grants), 64'd16);
    check_eq("cred_cnt_full", 64'(outstanding_out[3]), 64'd16);
    check_eq("cred_ready_blocked", 64'(bus.req_ready), 64'h0);
    bus.rsp_valid = 1'b1;
    bus.rsp_cu_id = 8'h04;
    @(negedge clock);
    bus.rsp_valid = 1'b0;
    #1;
    check_eq("cred_cnt_return", 64'(outstanding_out[3]), 64'd15);
    check_eq("cred_regrant", 64'(bus.req_ready), 64'h08);
    @(negedge clock); #1;
    check_eq("cred_cnt_refull", 64'(outstanding_out[3]), 64'd16);
    check_eq("cred_reblocked", 64'(bus.req_ready), 64'h0);
    bus.req_valid = '0;

    // 5. same-cycle credit, out-of-range response, saturation, enable
    do_reset();
    bus.req_valid = 8'h04;
    @(negedge clock);
    bus.req_valid = '0;
    #1;
    check_eq("same_cnt_pre", 64'(outstanding_out[2]), 64'd1);
    bus.req_valid = 8'h04;
    bus.rsp_valid = 1'b1;
    bus.rsp_cu_id = 8'h03;
    #1;
    check_eq("same_ready", 64'(bus.req_ready), 64'h04);
    @(negedge clock);
    bus.req_valid = '0;
    bus.rsp_valid = 1'b0;
    #1;
    check_eq("same_cnt_unchanged", 64'(outstanding_out[2]), 64'd1);
    check_eq("same_cu_id", 64'(bus.out_cmd.cu_id), 64'h03);
    bus.rsp_valid = 1'b1;
    bus.rsp_cu_id = 8'h20;
    @(negedge clock);
    bus.rsp_cu_id = 8'h02;
    @(negedge clock);
    bus.rsp_valid = 1'b0;
    #1;
    check_eq("oor_and_sat_cnts", 64'(outstanding_out), 64'h1 << 10);
    bus.rsp_valid = 1'b1;
    bus.rsp_cu_id = 8'h03;
    @(negedge clock);
    bus.rsp_valid = 1'b0;
    #1;
    check_eq("rsp_cnt2_zero", 64'(outstanding_out[2]), 64'd0);
    enabled_in    = 1'b0;
    bus.req_valid = 8'h04;
    #1;
    check_eq("dis_ready", 64'(bus.req_ready), 64'h0);
    @(negedge clock); #1;
    check_eq("dis_cnt2", 64'(outstanding_out[2]), 64'd0);
    check_eq("dis_drained", 64'(bus.out_valid), 64'h0);
    enabled_in = 1'b1;
    #1;
    check_eq("en_ready", 64'(bus.req_ready), 64'h04);
    bus.req_valid = '0;
    @(negedge clock);

    // 6. mid-stream reset with a held command and nonzero counters
    do_reset();
    bus.req_valid = '1;
    repeat (3) @(negedge clock);
    bus.out_ready = 1'b0;
    #1;
    check_eq("mid_pre_valid", 64'(bus.out_valid), 64'h1);
    check_eq("mid_pre_cu_id", 64'(bus.out_cmd.cu_id), 64'h03);
    check_eq("mid_pre_cnt1", 64'(outstanding_out[1]), 64'd1);
    rstn          = 1'b0;
    bus.req_valid = 8'h24;
    #1;
    check_eq("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    @(negedge clock);
    rstn = 1'b1;
    #1;
    check_eq("mid_out_valid", 64'(bus.out_valid), 64'h0);
    check_eq("mid_cnts", 64'(outstanding_out), 64'h0);
    check_eq("mid_lowest_ready", 64'(bus.req_ready), 64'h04);
    @(negedge clock); #1;
    check_eq("mid_grant_cu_id", 64'(bus.out_cmd.cu_id), 64'h03);
    bus.req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
